cmp_sort_ctrl: RTL and testbench

Sequencer that owns one shared 4-bit magnitude comparator and uses it to bubble-sort a buffer of N operands in place, ascending, performing one compare-and-swap per clock.
- Operands are loaded serially through a valid/ready input, then sorted; results are drained serially through a valid/ready output.
- Supports unsigned and two's-complement ordering, selected per job.
- Sits between the switch/keypad input logic and the display/readout path of the lab datapath.

---
 rtl/cmp_sort_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// Shared-comparator bubble sorter: serial load, in-place ascending sort (one compare-and-swap
// per clock), serial drain. Define CMP_SORT_EARLY_EXIT_EN to stop after a swap-free pass.
module cmp_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         signed_mode,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         done,
  output logic [7:0]   swap_cnt
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] ka;
    logic [W-1:0] kb;
    ka = a;
    kb = b;
    ka[W-1] = a[W-1] ^ sgn;
    kb[W-1] = b[W-1] ^ sgn;
    return ka > kb;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mem_q [N];
  logic [W-1:0]   mem_d [N];
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  pass_q, pass_d;
  logic [IW-1:0]  rd_q, rd_d;
  logic           mode_q, mode_d;
  logic [7:0]     swap_cnt_q, swap_cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           out_valid_q, out_valid_d;
  logic           done_q, done_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [W-1:0]   cmp_a, cmp_b;
  logic [IW-1:0]  last_idx;
  logic           do_swap;
  logic           exit_now;
`ifdef CMP_SORT_EARLY_EXIT_EN
  logic           swapped_q, swapped_d;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    rd_d       = rd_q;
    mode_d     = mode_q;
    swap_cnt_d = swap_cnt_q;
    done_d     = 1'b0;
    cmp_a      = mem_q[idx_q];
    cmp_b      = mem_q[idx_q + IW'(1)];
    last_idx   = IW'(N - 2) - pass_q;
    do_swap    = 1'b0;
    exit_now   = 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
    swapped_d  = swapped_q;
`endif
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[cnt_q[IW-1:0]] = in_data;
          cnt_d = cnt_q + CW'(1);
        end else if (start && (cnt_q == CW'(N))) begin
          state_d    = SORT;
          mode_d     = signed_mode;
          swap_cnt_d = 8'd0;
          pass_d     = '0;
          idx_d      = '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
          swapped_d  = 1'b0;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      SORT: begin
        do_swap = gt(cmp_a, cmp_b, mode_q);
        if (do_swap) begin
          mem_d[idx_q]         = cmp_b;
          mem_d[idx_q + IW'(1)] = cmp_a;
          swap_cnt_d = (swap_cnt_q == 8'hFF) ? swap_cnt_q : swap_cnt_q + 8'd1;
        end else begin
          swap_cnt_d = swap_cnt_q;
        end
`ifdef CMP_SORT_EARLY_EXIT_EN
        exit_now = (pass_q == IW'(N - 2)) || !(swapped_q || do_swap);
`else
        exit_now = (pass_q == IW'(N - 2));
`endif
        if (idx_q == last_idx) begin
          idx_d  = '0;
          pass_d = pass_q + IW'(1);
`ifdef CMP_SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          if (exit_now) begin
            state_d = DRAIN;
            rd_d    = '0;
          end else begin
            state_d = SORT;
          end
        end else begin
          idx_d = idx_q + IW'(1);
`ifdef CMP_SORT_EARLY_EXIT_EN
          swapped_d = swapped_q || do_swap;
`endif
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_q == IW'(N - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            rd_d = rd_q + IW'(1);
          end
        end else begin
          rd_d = rd_q;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == LOAD) && (cnt_d < CW'(N));
    busy_d      = (state_d == SORT) || (state_d == DRAIN);
    out_valid_d = (state_d == DRAIN);
    out_data_d  = mem_d[rd_d];
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      rd_q        <= '0;
      mode_q      <= 1'b0;
      swap_cnt_q  <= 8'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
      swapped_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      rd_q        <= rd_d;
      mode_q      <= mode_d;
      swap_cnt_q  <= swap_cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
      swapped_q   <= swapped_d;
`endif
    end
  end

  // Operand buffer; contents are meaningless after reset so it is not cleared
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign swap_cnt  = swap_cnt_q;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: directed vector table, hand-written corner
// sequences, and randomized jobs checked against a rank/inversion-count reference model.
module tb_cmp_sort_ctrl;
  localparam int N = 8;
  localparam int W = 4;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         signed_mode;
  logic         start;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         done;
  logic [7:0]   swap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N*W-1:0] vec;    // element 0 in the most significant nibble
    logic           mode;
    logic [N*W-1:0] exp;
    int             swaps;
    int             hold_at;
  } vec_t;

  vec_t         tbl[7];
  logic [W-1:0] got[N];
  int           sort_len;

  cmp_sort_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .signed_mode(signed_mode), .start(start), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done(done), .swap_cnt(swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] elem(input logic [N*W-1:0] v, input int i);
    return v[(N-1-i)*W +: W];
  endfunction

  // Reference: stable rank placement; bubble-sort swap count equals the inversion count.
  function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] v, input logic m,
                                                 output int inv);
    int key[N];
    int pos;
    logic [N*W-1:0] r;
    r = '0;
    inv = 0;
    for (int i = 0; i < N; i++) key[i] = m ? int'($signed(elem(v, i))) : int'(elem(v, i));
    for (int i = 0; i < N; i++) begin
      pos = 0;
      for (int j = 0; j < N; j++) begin
        if (key[j] < key[i] || (key[j] == key[i] && j < i)) pos++;
        if (j > i && key[i] > key[j]) inv++;
      end
      r[(N-1-pos)*W +: W] = elem(v, i);
    end
    return r;
  endfunction

  function automatic int exp_len(input int inv);
`ifdef CMP_SORT_EARLY_EXIT_EN
    return (inv == 0) ? N - 1 : -1;
`else
    return N * (N - 1) / 2;
`endif
  endfunction

  task automatic load_ops(input logic [N*W-1:0] v, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check("load_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = elem(v, i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_and_sort(input logic m);
    signed_mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    signed_mode = ~m;
    check("swap_clr", swap_cnt, 0);
    sort_len = 0;
    while (busy && !out_valid && sort_len < 200) begin
      sort_len++;
      tick();
    end
  endtask

  task automatic drain(input int hold_at);
    int k = 0;
    int cyc = 0;
    int held = 0;
    int done_seen = 0;
    logic [W-1:0] hold_val = '0;
    while (k < N && cyc < 200) begin
      if (done) done_seen++;
      if (out_valid) begin
        if (k == hold_at && held < 4) begin
          out_ready = 1'b0;
          if (held == 0) hold_val = out_data;
          else check("hold_stable", out_data, hold_val);
          held++;
        end else begin
          out_ready = 1'b1;
          got[k] = out_data;
          k++;
        end
      end else begin
        out_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", k, N);
    check("early_done", done_seen, 0);
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    check("ready_after", in_ready, 1);
    tick();
    check("done_single", done, 0);
  endtask

  task automatic run_job(input logic [N*W-1:0] v, input logic m, input logic [N*W-1:0] e,
                         input int swaps, input int hold_at);
    int el;
    load_ops(v, 0, N - 1);
    check("full_ready", in_ready, 0);
    start_and_sort(m);
    el = exp_len(swaps);
    if (el >= 0) check("sort_len", sort_len, el);
    else check("sort_len_range", (sort_len >= N - 1) && (sort_len <= N * (N - 1) / 2), 1);
    drain(hold_at);
    for (int i = 0; i < N; i++) check("out_data", got[i], elem(e, i));
    check("swap_cnt", swap_cnt, swaps);
  endtask

  initial begin
    logic [N*W-1:0] rv;
    logic [N*W-1:0] re;
    logic           rm;
    int             rinv;

    tbl[0] = '{vec: 32'h76543210, mode: 1'b0, exp: 32'h01234567, swaps: 28, hold_at: -1};
    tbl[1] = '{vec: 32'h87F0193E, mode: 1'b1, exp: 32'h89EF0137, swaps: 13, hold_at: -1};
    tbl[2] = '{vec: 32'h87F0193E, mode: 1'b0, exp: 32'h013789EF, swaps: 13, hold_at: -1};
    tbl[3] = '{vec: 32'h01234567, mode: 1'b0, exp: 32'h01234567, swaps: 0,  hold_at: -1};
    tbl[4] = '{vec: 32'h3A5C1F08, mode: 1'b0, exp: 32'h01358ACF, swaps: 14, hold_at: 3};
    tbl[5] = '{vec: 32'hFFFF0000, mode: 1'b1, exp: 32'hFFFF0000, swaps: 0,  hold_at: -1};
    tbl[6] = '{vec: 32'hFFFF0000, mode: 1'b0, exp: 32'h0000FFFF, swaps: 16, hold_at: 0};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; signed_mode = 1'b0;
    start = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_swap_cnt", swap_cnt, 0);
    rstn = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    for (int t = 0; t < 7; t++)
      run_job(tbl[t].vec, tbl[t].mode, tbl[t].exp, tbl[t].swaps, tbl[t].hold_at);

    // Early start is ignored until all N operands are present
    load_ops(tbl[0].vec, 0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("early_start_busy", busy, 0);
    check("early_start_ready", in_ready, 1);
    tick();
    check("early_start_idle", busy, 0);
    load_ops(tbl[0].vec, 5, N - 1);
    check("late_full_ready", in_ready, 0);
    start_and_sort(1'b0);
    check("late_sort_len", sort_len, exp_len(28));
    drain(-1);
    for (int i = 0; i < N; i++) check("late_out", got[i], elem(tbl[0].exp, i));
    check("late_swaps", swap_cnt, 28);

    // Reset during the 10th SORT cycle aborts the job
    load_ops(tbl[0].vec, 0, N - 1);
    signed_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid_sort_busy", busy && !out_valid, 1);
    rstn = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_swaps", swap_cnt, 0);
    check("abort_done", done, 0);
    rstn = 1'b1;
    tick();
    check("abort_ready", in_ready, 1);
    run_job(tbl[0].vec, tbl[0].mode, tbl[0].exp, tbl[0].swaps, -1);

    for (int r = 0; r < 16; r++) begin
      rv = {$urandom, $urandom} & {N*W{1'b1}};
      rm = 1'($urandom_range(0, 1));
      re = model_sort(rv, rm, rinv);
      run_job(rv, rm, re, rinv, int'($urandom_range(0, N)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
